// File: rtl/of_action_pkg.sv
// Shared definitions for the OpenFlow action engine: action-word layout,
// header/MAC field positions and the packet-walk state encoding.
package of_action_pkg;

  // Flag bit indices inside the 4-bit flags field
  localparam int FLAG_DROP     = 0;
  localparam int FLAG_SET_SRC  = 1;
  localparam int FLAG_SET_DST  = 2;
  localparam int FLAG_SET_PORT = 3;

  localparam int FLAGS_W = 4;
  localparam int MAC_W   = 48;

  // Field offsets measured from the bit just above port_map
  localparam int ACT_SRC_OFS   = 0;
  localparam int ACT_DST_OFS   = 48;
  localparam int ACT_FLAGS_OFS = 96;

  // Module header identification and output-port field
  localparam logic [7:0] IO_HDR_CTRL_DEFAULT = 8'hFF;
  localparam int HDR_PORT_LSB = 48;
  localparam int HDR_PORT_W   = 16;

  // MAC placement in the first two payload words
  localparam int W1_DST_LSB    = 16;
  localparam int W1_SRC_HI_W   = 16;
  localparam int W2_SRC_LO_LSB = 32;
  localparam int W2_SRC_LO_W   = 32;

  typedef enum logic [2:0] {
    WAIT_ACT = 3'd0,
    HDR      = 3'd1,
    DATA1    = 3'd2,
    DATA2    = 3'd3,
    BODY     = 3'd4
  } state_e;

  // A packet is dropped on an explicit drop flag or when a port rewrite
  // would leave it with no destination queue at all.
  function automatic logic act_drops(input logic [FLAGS_W-1:0] flags,
                                     input logic map_zero);
    return flags[FLAG_DROP] | (flags[FLAG_SET_PORT] & map_zero);
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout shows the head entry whenever
// empty is low. Writes while full and reads while empty are ignored.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]          mem_r [0:DEPTH-1];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
  logic [MAX_DEPTH_BITS:0]   count_r;
  logic                      do_wr_s;
  logic                      do_rd_s;

  assign full    = (count_r == DEPTH_CNT);
  assign empty   = (count_r == {(MAX_DEPTH_BITS+1){1'b0}});
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign dout    = mem_r[rd_ptr_r];

  // Storage array: written at the tail, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
      rd_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
      count_r  <= {(MAX_DEPTH_BITS+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + MAX_DEPTH_BITS'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + MAX_DEPTH_BITS'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + (MAX_DEPTH_BITS+1)'(1);
        2'b01:   count_r <= count_r - (MAX_DEPTH_BITS+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/of_action_engine.sv
// OpenFlow action engine: binds one queued action word to each packet in
// arrival order and applies port rewrite, MAC rewrite and drop on the fly.
module of_action_engine
  import of_action_pkg::*;
#(
  parameter int                  DATA_WIDTH          = 64,
  parameter int                  CTRL_WIDTH          = DATA_WIDTH/8,
  parameter int                  NUM_PORTS           = 8,
  parameter int                  ACT_FIFO_DEPTH_BITS = 2,
  parameter logic [CTRL_WIDTH-1:0] IO_HDR_CTRL       = IO_HDR_CTRL_DEFAULT,
  parameter int                  ACT_WIDTH           = 4+96+NUM_PORTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [ACT_WIDTH-1:0]  action_data,
  input  logic                  action_valid,
  output logic                  act_fifo_full,
  output logic                  stat_fwd,
  output logic                  stat_drop,
  output logic                  stat_act_ovf
);

  state_e                 state_r;
  state_e                 phase_s;
  logic [ACT_WIDTH-1:0]   act_r;
  logic [ACT_WIDTH-1:0]   head_s;
  logic                   empty_s;
  logic                   full_s;
  logic                   fifo_wr_s;
  logic                   pop_s;
  logic                   eop_s;
  logic                   drop_s;
  logic [FLAGS_W-1:0]     flags_s;
  logic [MAC_W-1:0]       dst_s;
  logic [MAC_W-1:0]       src_s;
  logic [NUM_PORTS-1:0]   map_s;
  logic [DATA_WIDTH-1:0]  rewr_s;

  assign flags_s = act_r[NUM_PORTS+ACT_FLAGS_OFS +: FLAGS_W];
  assign dst_s   = act_r[NUM_PORTS+ACT_DST_OFS +: MAC_W];
  assign src_s   = act_r[NUM_PORTS+ACT_SRC_OFS +: MAC_W];
  assign map_s   = act_r[0 +: NUM_PORTS];
  assign drop_s  = act_drops(flags_s, (map_s == {NUM_PORTS{1'b0}}));

  assign in_rdy        = out_rdy && (state_r != WAIT_ACT);
  assign fifo_wr_s     = action_valid && !full_s;
  assign act_fifo_full = full_s;
  assign eop_s         = in_wr && (in_ctrl != {CTRL_WIDTH{1'b0}}) &&
                         ((state_r == DATA2) || (state_r == BODY));

  fallthrough_small_fifo #(
    .WIDTH          (ACT_WIDTH),
    .MAX_DEPTH_BITS (ACT_FIFO_DEPTH_BITS)
  ) u_act_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (action_data),
    .wr_en (fifo_wr_s),
    .rd_en (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Rewrites one word according to where it sits in the packet
  function automatic logic [DATA_WIDTH-1:0] rewrite_word(
    input state_e                phase,
    input logic [DATA_WIDTH-1:0] data,
    input logic [CTRL_WIDTH-1:0] ctrl,
    input logic [FLAGS_W-1:0]    flags,
    input logic [MAC_W-1:0]      dst,
    input logic [MAC_W-1:0]      src,
    input logic [NUM_PORTS-1:0]  map
  );
    logic [DATA_WIDTH-1:0] w;
    w = data;
    case (phase)
      HDR: begin
        if ((ctrl == IO_HDR_CTRL) && flags[FLAG_SET_PORT]) begin
          w[HDR_PORT_LSB +: HDR_PORT_W] = HDR_PORT_W'(map);
        end else begin
          w = data;
        end
      end
      DATA1: begin
        if (flags[FLAG_SET_DST]) begin
          w[W1_DST_LSB +: MAC_W] = dst;
        end else begin
          w[W1_DST_LSB +: MAC_W] = data[W1_DST_LSB +: MAC_W];
        end
        if (flags[FLAG_SET_SRC]) begin
          w[0 +: W1_SRC_HI_W] = src[MAC_W-1 -: W1_SRC_HI_W];
        end else begin
          w[0 +: W1_SRC_HI_W] = data[0 +: W1_SRC_HI_W];
        end
      end
      DATA2: begin
        if (flags[FLAG_SET_SRC]) begin
          w[W2_SRC_LO_LSB +: W2_SRC_LO_W] = src[0 +: W2_SRC_LO_W];
        end else begin
          w = data;
        end
      end
      default: w = data;
    endcase
    return w;
  endfunction

  // The first ctrl==0 word seen in HDR is itself the first payload word,
  // so it is rewritten with the DATA1 rules.
  always_comb begin
    phase_s = state_r;
    if ((state_r == HDR) && (in_ctrl == {CTRL_WIDTH{1'b0}})) begin
      phase_s = DATA1;
    end else begin
      phase_s = state_r;
    end
  end

  // Pop the next action when idle or at end of packet, so packets chain without a bubble
  always_comb begin
    pop_s = 1'b0;
    if (!empty_s && ((state_r == WAIT_ACT) || eop_s)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign rewr_s = rewrite_word(phase_s, in_data, in_ctrl, flags_s, dst_s, src_s, map_s);

  // Packet-walk FSM with registered datapath and statistics outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= WAIT_ACT;
      act_r        <= {ACT_WIDTH{1'b0}};
      out_data     <= {DATA_WIDTH{1'b0}};
      out_ctrl     <= {CTRL_WIDTH{1'b0}};
      out_wr       <= 1'b0;
      stat_fwd     <= 1'b0;
      stat_drop    <= 1'b0;
      stat_act_ovf <= 1'b0;
    end else begin
      out_wr       <= in_wr && !drop_s;
      out_data     <= rewr_s;
      out_ctrl     <= in_ctrl;
      stat_fwd     <= eop_s && !drop_s;
      stat_drop    <= eop_s && drop_s;
      stat_act_ovf <= action_valid && full_s;
      case (state_r)
        WAIT_ACT: begin
          if (pop_s) begin
            act_r   <= head_s;
            state_r <= HDR;
          end
        end
        HDR: begin
          if (in_wr && (in_ctrl == {CTRL_WIDTH{1'b0}})) begin
            state_r <= DATA2;
          end
        end
        DATA1: begin
          if (in_wr) begin
            state_r <= DATA2;
          end
        end
        DATA2, BODY: begin
          if (eop_s) begin
            if (pop_s) begin
              act_r   <= head_s;
              state_r <= HDR;
            end else begin
              state_r <= WAIT_ACT;
            end
          end else if (in_wr && (state_r == DATA2)) begin
            state_r <= BODY;
          end
        end
        default: state_r <= WAIT_ACT;
      endcase
    end
  end

endmodule
